// File: rtl/kernel_loader.sv
// Streams 64-bit kernel rows into the dual-port kernel SRAM, pairing rows k and 8+k of each 16-row block.
// Define KLOAD_CHECKSUM_EN to build the XOR checksum driven on load_sum.
`ifndef KMEM_ADDR_WIDTH
`define KMEM_ADDR_WIDTH 12
`endif

module kernel_loader (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load_st,
   input  logic [`KMEM_ADDR_WIDTH-4:0]   Base_addr,
   input  logic [9:0]                    Block_count,
   input  logic [63:0]                   in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [`KMEM_ADDR_WIDTH-1:0]   kernel_wa1,
   output logic [`KMEM_ADDR_WIDTH-1:0]   kernel_wa2,
   output logic [63:0]                   kernel_wd1,
   output logic [63:0]                   kernel_wd2,
   output logic                          kernel_wen1,
   output logic                          kernel_wen2,
   output logic                          load_busy,
   output logic                          load_done,
   output logic [63:0]                   load_sum
);

   localparam int unsigned AW = `KMEM_ADDR_WIDTH;
   localparam int unsigned RW = AW - 3;

   typedef enum logic [1:0] {IDLE, FILL, PAIR, DONE} state_e;

   state_e          state_q, state_d;
   logic [2:0]      k_q, k_d;
   logic [RW-1:0]   base_q, base_d;
   logic [9:0]      blocks_q, blocks_d;
   logic            wen_q, wen_d;
   logic [AW-1:0]   wa1_q, wa1_d, wa2_q, wa2_d;
   logic [63:0]     wd1_q, wd1_d, wd2_q, wd2_d;
   logic [63:0]     hold_q [8];
   logic            hold_we;
   logic            hs;
   logic [RW-1:0]   row1, row2;

   assign in_ready  = (state_q == FILL) || (state_q == PAIR);
   assign load_busy = (state_q != IDLE);
   assign load_done = (state_q == DONE);
   assign hs        = in_valid && in_ready;
   assign row1      = base_q + RW'(k_q);
   assign row2      = row1 + RW'(8);

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      base_d   = base_q;
      blocks_d = blocks_q;
      wen_d    = 1'b0;
      wa1_d    = wa1_q;
      wa2_d    = wa2_q;
      wd1_d    = wd1_q;
      wd2_d    = wd2_q;
      hold_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_st) begin
               if (Block_count != 10'd0) begin
                  state_d  = FILL;
                  k_d      = 3'd0;
                  base_d   = Base_addr;
                  blocks_d = Block_count;
               end else begin
                  state_d = DONE;
               end
            end
         end
         FILL: begin
            if (hs) begin
               hold_we = 1'b1;
               k_d     = k_q + 3'd1;
               if (k_q == 3'd7) state_d = PAIR;
            end
         end
         PAIR: begin
            if (hs) begin
               wen_d = 1'b1;
               wa1_d = {row1, 3'b000};
               wa2_d = {row2, 3'b000};
               wd1_d = hold_q[k_q];
               wd2_d = in_data;
               k_d   = k_q + 3'd1;
               // blocks_q counts the block in flight, so 1 means this is the last one
               if (k_q == 3'd7) begin
                  if (blocks_q != 10'd1) begin
                     blocks_d = blocks_q - 10'd1;
                     base_d   = base_q + RW'(16);
                     state_d  = FILL;
                  end else begin
                     state_d = DONE;
                  end
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         k_q      <= '0;
         base_q   <= '0;
         blocks_q <= '0;
         wen_q    <= 1'b0;
         wa1_q    <= '0;
         wa2_q    <= '0;
         wd1_q    <= '0;
         wd2_q    <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         base_q   <= base_d;
         blocks_q <= blocks_d;
         wen_q    <= wen_d;
         wa1_q    <= wa1_d;
         wa2_q    <= wa2_d;
         wd1_q    <= wd1_d;
         wd2_q    <= wd2_d;
      end
   end

   always_ff @(posedge clk) begin
      if (hold_we) hold_q[k_q] <= in_data;
   end

   assign kernel_wen1 = wen_q;
   assign kernel_wen2 = wen_q;
   assign kernel_wa1  = wa1_q;
   assign kernel_wa2  = wa2_q;
   assign kernel_wd1  = wd1_q;
   assign kernel_wd2  = wd2_q;

`ifdef KLOAD_CHECKSUM_EN
   logic [63:0] sum_q;

   always_ff @(posedge clk) begin
      if (rst)                              sum_q <= '0;
      else if (state_q == IDLE && load_st)  sum_q <= '0;
      else if (hs)                          sum_q <= sum_q ^ in_data;
   end

   assign load_sum = sum_q;
`else
   assign load_sum = '0;
`endif

endmodule

// File: tb/tb_kernel_loader.sv
// Directed bench for kernel_loader: pairing layout, latency, stalls, zero-block, wrap, ignored start, mid-load reset.
`ifndef KMEM_ADDR_WIDTH
`define KMEM_ADDR_WIDTH 12
`endif

module tb_kernel_loader;

   localparam int unsigned AW = `KMEM_ADDR_WIDTH;
   localparam int unsigned RW = AW - 3;

   logic            clk = 1'b0;
   logic            rst, load_st, in_valid, in_ready;
   logic [RW-1:0]   Base_addr;
   logic [9:0]      Block_count;
   logic [63:0]     in_data;
   logic [AW-1:0]   kernel_wa1, kernel_wa2;
   logic [63:0]     kernel_wd1, kernel_wd2, load_sum;
   logic            kernel_wen1, kernel_wen2, load_busy, load_done;

   always #5 clk = ~clk;

   kernel_loader dut (
      .clk(clk), .rst(rst), .load_st(load_st), .Base_addr(Base_addr), .Block_count(Block_count),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .kernel_wa1(kernel_wa1), .kernel_wa2(kernel_wa2), .kernel_wd1(kernel_wd1), .kernel_wd2(kernel_wd2),
      .kernel_wen1(kernel_wen1), .kernel_wen2(kernel_wen2),
      .load_busy(load_busy), .load_done(load_done), .load_sum(load_sum)
   );

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [AW-1:0] wa1, wa2;
      logic [63:0]   wd1, wd2;
      logic          both;
      logic          hs_prev;
   } wr_t;

   wr_t          wq[$];
   int unsigned  cyc = 0;
   logic [63:0]  d [64];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Logs every write cycle and whether a handshake was pending in the cycle before it.
   initial begin
      wr_t w;
      logic hs_prev;
      hs_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (kernel_wen1 || kernel_wen2) begin
            w.wa1 = kernel_wa1; w.wa2 = kernel_wa2;
            w.wd1 = kernel_wd1; w.wd2 = kernel_wd2;
            w.both = kernel_wen1 && kernel_wen2;
            w.hs_prev = hs_prev;
            wq.push_back(w);
         end
         hs_prev = in_valid && in_ready;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic start(input logic [RW-1:0] base, input logic [9:0] n, output int unsigned c0);
      Base_addr = base; Block_count = n; load_st = 1'b1; c0 = cyc;
      @(posedge clk); #1;
      load_st = 1'b0;
   endtask

   task automatic send(input int unsigned first, input int unsigned n, input bit gaps);
      for (int unsigned i = 0; i < n; i++) begin
         int unsigned g;
         bit ok;
         g = gaps ? ((i % 5 == 2) ? 2 : ((i % 7 == 3) ? 1 : 0)) : 0;
         in_valid = 1'b0;
         repeat (g) begin @(posedge clk); #1; end
         in_valid = 1'b1;
         in_data  = d[first + i];
         ok = 1'b0;
         for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
         end
         if (!ok) chk("ready_timeout", 64'(ok), 64'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int unsigned dc);
      bit ok;
      ok = 1'b0; dc = 0;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (load_done) begin ok = 1'b1; dc = cyc; break; end
      end
      if (!ok) chk("done_timeout", 64'(ok), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_writes(input logic [RW-1:0] base, input int unsigned nwr,
                               input int unsigned first, input string tag);
      chk({tag, "_nwr"}, 64'(wq.size()), 64'(nwr));
      for (int unsigned i = 0; i < nwr && i < wq.size(); i++) begin
         int unsigned b, k;
         logic [RW-1:0] r1, r2;
         b = i / 8; k = i % 8;
         r1 = base + RW'(16 * b + k);
         r2 = base + RW'(16 * b + 8 + k);
         chk($sformatf("%s_wa1_%0d", tag, i), 64'(wq[i].wa1), 64'({r1, 3'b000}));
         chk($sformatf("%s_wa2_%0d", tag, i), 64'(wq[i].wa2), 64'({r2, 3'b000}));
         chk($sformatf("%s_wd1_%0d", tag, i), wq[i].wd1, d[first + 16 * b + k]);
         chk($sformatf("%s_wd2_%0d", tag, i), wq[i].wd2, d[first + 16 * b + 8 + k]);
         chk($sformatf("%s_wen_%0d", tag, i), 64'(wq[i].both), 64'd1);
         chk($sformatf("%s_hs_%0d", tag, i), 64'(wq[i].hs_prev), 64'd1);
      end
      wq.delete();
   endtask

   task automatic chk_idle(input string tag);
      @(negedge clk);
      chk({tag, "_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_wen1"}, 64'(kernel_wen1), 64'd0);
      chk({tag, "_wen2"}, 64'(kernel_wen2), 64'd0);
      chk({tag, "_wa1"}, 64'(kernel_wa1), 64'd0);
      chk({tag, "_wa2"}, 64'(kernel_wa2), 64'd0);
      chk({tag, "_wd1"}, kernel_wd1, 64'd0);
      chk({tag, "_wd2"}, kernel_wd2, 64'd0);
      chk({tag, "_busy"}, 64'(load_busy), 64'd0);
      chk({tag, "_done"}, 64'(load_done), 64'd0);
      chk({tag, "_sum"}, load_sum, 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int unsigned c0, dc;
      logic [63:0] exp_sum;
      rst = 1'b1; load_st = 1'b0; in_valid = 1'b0; in_data = '0;
      Base_addr = '0; Block_count = '0;
      @(posedge clk); #1;
      chk_idle("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // single block, unstalled
      for (int i = 0; i < 16; i++) d[i] = 64'h1000 + 64'(i);
      start(RW'(16), 10'd1, c0);
      send(0, 16, 1'b0);
      wait_done(dc);
      chk("single_latency", 64'(dc - c0), 64'd17);
      check_writes(RW'(16), 8, 0, "single");
      chk("single_sum", load_sum, 64'd0);
      chk("single_busy_after", 64'(load_busy), 64'd0);

      // three blocks with stalls
      for (int i = 0; i < 48; i++) d[i] = 64'hA5A5_0000_0000_0000 + (64'(i) << 8) + 64'(i);
      start(RW'(48), 10'd3, c0);
      send(0, 48, 1'b1);
      wait_done(dc);
      check_writes(RW'(48), 24, 0, "three");

      // zero blocks
      start(RW'(5), 10'd0, c0);
      @(negedge clk);
      chk("zero_done", 64'(load_done), 64'd1);
      chk("zero_ready0", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("zero_done_clr", 64'(load_done), 64'd0);
      chk("zero_ready1", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      chk("zero_nwr", 64'(wq.size()), 64'd0);
      wq.delete();

      // address wrap
      for (int i = 0; i < 16; i++) d[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
      start(RW'((1 << RW) - 8), 10'd1, c0);
      send(0, 16, 1'b0);
      wait_done(dc);
      check_writes(RW'((1 << RW) - 8), 8, 0, "wrap");

      // ignored start during PAIR, then reset after row 11
      for (int i = 0; i < 16; i++) d[i] = 64'h5500_0000_0000_0000 + 64'(i * 3);
      start(RW'(64), 10'd1, c0);
      send(0, 9, 1'b0);
      Base_addr = RW'(256); Block_count = 10'd5; load_st = 1'b1;
      @(posedge clk); #1;
      load_st = 1'b0;
      @(negedge clk);
      chk("ign_busy", 64'(load_busy), 64'd1);
      chk("ign_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      send(9, 2, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_wen", 64'(kernel_wen1), 64'd0);
      chk("rst_wa1", 64'(kernel_wa1), 64'd0);
      chk("rst_wd2", kernel_wd2, 64'd0);
      chk("rst_busy", 64'(load_busy), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd0);
      chk("rst_sum", load_sum, 64'd0);
      @(posedge clk); #1;
      check_writes(RW'(64), 3, 0, "prerst");

      // fresh load after reset
      start(RW'(160), 10'd1, c0);
      send(0, 16, 1'b0);
      wait_done(dc);
      chk("fresh_latency", 64'(dc - c0), 64'd17);
      check_writes(RW'(160), 8, 0, "fresh");

      // all-ones rows with one zero row
      for (int i = 0; i < 16; i++) d[i] = (i == 5) ? 64'd0 : '1;
      start(RW'(0), 10'd1, c0);
      send(0, 16, 1'b0);
      wait_done(dc);
      check_writes(RW'(0), 8, 0, "ones");
`ifdef KLOAD_CHECKSUM_EN
      exp_sum = 64'hFFFF_FFFF_FFFF_FFFF;
`else
      exp_sum = 64'd0;
`endif
      chk("ones_sum", load_sum, exp_sum);
      repeat (3) @(posedge clk);
      #1;
      chk("ones_sum_stable", load_sum, exp_sum);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
